dram_port_arbiter: RTL and testbench

//  Shares the single data-memory port (rwmem via mem_interface) between two requesters:
//  R0 = DLX data port, R1 = debug/loader master (bench preload, memory dump).

---
 rtl/dram_port_arbiter_if.sv | 45 ++++
 rtl/dram_port_arbiter.sv | 117 +++++++++++
 tb/tb_dram_port_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dram_port_arbiter_if.sv
// Bundle of the two requester ports and the memory port around dram_port_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters plus memory).
interface dram_port_arbiter_if #(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned WORD_SIZE    = 32
);
  logic                    r0_enable;
  logic                    r0_read_not_write;
  logic [ADDRESS_SIZE-1:0] r0_address;
  logic [WORD_SIZE-1:0]    r0_wdata;
  logic [WORD_SIZE-1:0]    r0_rdata;
  logic                    r0_ready;

  logic                    r1_enable;
  logic                    r1_read_not_write;
  logic [ADDRESS_SIZE-1:0] r1_address;
  logic [WORD_SIZE-1:0]    r1_wdata;
  logic [WORD_SIZE-1:0]    r1_rdata;
  logic                    r1_ready;

  logic                    mem_enable;
  logic                    mem_read_not_write;
  logic [ADDRESS_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0]    mem_wdata;
  logic [WORD_SIZE-1:0]    mem_rdata;
  logic                    mem_ready;

  modport slave (
    input  r0_enable, r0_read_not_write, r0_address, r0_wdata,
    output r0_rdata, r0_ready,
    input  r1_enable, r1_read_not_write, r1_address, r1_wdata,
    output r1_rdata, r1_ready,
    output mem_enable, mem_read_not_write, mem_address, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output r0_enable, r0_read_not_write, r0_address, r0_wdata,
    input  r0_rdata, r0_ready,
    output r1_enable, r1_read_not_write, r1_address, r1_wdata,
    input  r1_rdata, r1_ready,
    input  mem_enable, mem_read_not_write, mem_address, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the DLX data port (R0) and a
// debug/loader master (R1); each access waits for MEM_READY or aborts after a timeout.
module dram_port_arbiter #(
  parameter int unsigned ADDRESS_SIZE   = 32,
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  dram_port_arbiter_if.slave  bus,
  output logic [1:0]          o_grant,
  output logic                o_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                  r_state;
  logic                    r_last_grant;  // 0 = R0 served last, 1 = R1 served last
  logic                    r_owner;
  logic [CNT_W-1:0]        r_cnt;
  logic [1:0]              r_grant;
  logic                    r_err;
  logic                    r_ready0;
  logic                    r_ready1;
  logic [WORD_SIZE-1:0]    r_rdata0;
  logic [WORD_SIZE-1:0]    r_rdata1;
  logic                    r_mem_enable;
  logic                    r_mem_rnw;
  logic [ADDRESS_SIZE-1:0] r_mem_address;
  logic [WORD_SIZE-1:0]    r_mem_wdata;

  logic w_any_req;
  logic w_pick_r1;

  assign w_any_req = bus.r0_enable | bus.r1_enable;
  // R1 wins when it is the only requester, or on a tie when R0 was served last.
  assign w_pick_r1 = bus.r1_enable & (~bus.r0_enable | ~r_last_grant);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_cnt         <= '0;
      r_grant       <= 2'b00;
      r_err         <= 1'b0;
      r_ready0      <= 1'b0;
      r_ready1      <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_mem_enable  <= 1'b0;
      r_mem_rnw     <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner       <= w_pick_r1;
            r_grant       <= w_pick_r1 ? 2'b10 : 2'b01;
            r_mem_enable  <= 1'b1;
            r_mem_rnw     <= w_pick_r1 ? bus.r1_read_not_write : bus.r0_read_not_write;
            r_mem_address <= w_pick_r1 ? bus.r1_address : bus.r0_address;
            r_mem_wdata   <= w_pick_r1 ? bus.r1_wdata : bus.r0_wdata;
            r_cnt         <= '0;
            r_state       <= StAccess;
          end
        end
        StAccess: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (bus.mem_ready) begin
            if (r_mem_rnw) begin
              if (r_owner) r_rdata1 <= bus.mem_rdata;
              else         r_rdata0 <= bus.mem_rdata;
            end
            r_mem_enable <= 1'b0;
            r_ready0     <= ~r_owner;
            r_ready1     <= r_owner;
            r_state      <= StDone;
          end else if (r_cnt == CNT_LAST) begin
            r_mem_enable <= 1'b0;
            r_err        <= 1'b1;
            r_ready0     <= ~r_owner;
            r_ready1     <= r_owner;
            r_state      <= StDone;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_ready0     <= 1'b0;
          r_ready1     <= 1'b0;
          r_err        <= 1'b0;
          r_grant      <= 2'b00;
          r_last_grant <= r_owner;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.r0_rdata           = r_rdata0;
  assign bus.r0_ready           = r_ready0;
  assign bus.r1_rdata           = r_rdata1;
  assign bus.r1_ready           = r_ready1;
  assign bus.mem_enable         = r_mem_enable;
  assign bus.mem_read_not_write = r_mem_rnw;
  assign bus.mem_address        = r_mem_address;
  assign bus.mem_wdata          = r_mem_wdata;
  assign o_grant                = r_grant;
  assign o_err                  = r_err;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Randomized bench for dram_port_arbiter: requesters and a memory with random latency are
// checked against a transaction-level round-robin model.
module tb_dram_port_arbiter;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int TO = 16;
  localparam int N_ITER = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       err;

  always #5 clk = ~clk;

  dram_port_arbiter_if #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW)) bus ();

  dram_port_arbiter #(
    .ADDRESS_SIZE  (AW),
    .WORD_SIZE     (WW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus),
    .o_grant(grant),
    .o_err  (err)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Model of each requester's pending request and its visible read-data register.
  bit          pend[2];
  logic        rnw_m[2];
  logic [31:0] addr_m[2];
  logic [31:0] wdata_m[2];
  logic [31:0] rdata_exp[2];
  int          last_owner;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic new_req(input int r, input logic rnw);
    pend[r]    = 1'b1;
    rnw_m[r]   = rnw;
    addr_m[r]  = $urandom;
    wdata_m[r] = $urandom;
  endtask

  task automatic apply_reqs();
    bus.r0_enable         = pend[0];
    bus.r0_read_not_write = rnw_m[0];
    bus.r0_address        = addr_m[0];
    bus.r0_wdata          = wdata_m[0];
    bus.r1_enable         = pend[1];
    bus.r1_read_not_write = rnw_m[1];
    bus.r1_address        = addr_m[1];
    bus.r1_wdata          = wdata_m[1];
  endtask

  task automatic check_rdata(input string tag);
    check({tag, "_r0_rdata"}, 64'(bus.r0_rdata), 64'(rdata_exp[0]));
    check({tag, "_r1_rdata"}, 64'(bus.r1_rdata), 64'(rdata_exp[1]));
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      pend[r]      = 1'b0;
      rnw_m[r]     = 1'b0;
      addr_m[r]    = '0;
      wdata_m[r]   = '0;
      rdata_exp[r] = '0;
    end
    last_owner = 1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 64'(grant), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_ready"}, 64'({bus.r0_ready, bus.r1_ready}), 64'(0));
    check({tag, "_mem_en"}, 64'(bus.mem_enable), 64'(0));
    check({tag, "_mem_rnw"}, 64'(bus.mem_read_not_write), 64'(0));
    check({tag, "_mem_addr"}, 64'(bus.mem_address), 64'(0));
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check_rdata(tag);
  endtask

  initial begin
    int          owner;
    int          ready_edge;
    bit          done;
    bit          timed;
    bit          was_reset;
    bit          force_r1;
    bit          reset_it;
    logic [31:0] mem_data;
    logic [1:0]  grant_exp;

    model_reset();
    apply_reqs();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    force_r1      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int it = 0; it < N_ITER; it++) begin
      // IDLE cycle: requesters without a pending request may raise a new one.
      if (force_r1) begin
        new_req(1, 1'b1);
        force_r1 = 1'b0;
      end else begin
        for (int r = 0; r < 2; r++)
          if (!pend[r] && (it == 0 || $urandom_range(0, 2) != 0))
            new_req(r, logic'($urandom_range(0, 1)));
      end
      apply_reqs();
      bus.mem_ready = logic'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;

      if (!pend[0] && !pend[1]) begin
        @(posedge clk);
        #1;
        check("idle_grant", 64'(grant), 64'(0));
        check("idle_mem_en", 64'(bus.mem_enable), 64'(0));
        @(negedge clk);
        continue;
      end

      if (pend[0] && pend[1]) owner = 1 - last_owner;
      else                    owner = pend[0] ? 0 : 1;
      grant_exp = (owner == 0) ? 2'b01 : 2'b10;

      reset_it = (it == 120 || it == 240);
      if (reset_it || it == 5 || $urandom_range(0, 9) == 0) ready_edge = 0;
      else if (it == 6 || $urandom_range(0, 9) == 0)      ready_edge = TO;
      else                                                ready_edge = $urandom_range(1, 4);

      @(posedge clk);
      #1;
      check("grant_start", 64'(grant), 64'(grant_exp));
      check("mem_en_start", 64'(bus.mem_enable), 64'(1));
      check("mem_addr_start", 64'(bus.mem_address), 64'(addr_m[owner]));
      check("mem_wdata_start", 64'(bus.mem_wdata), 64'(wdata_m[owner]));
      check("mem_rnw_start", 64'(bus.mem_read_not_write), 64'(rnw_m[owner]));
      check("ready_start", 64'({bus.r0_ready, bus.r1_ready}), 64'(0));

      done      = 1'b0;
      timed     = 1'b0;
      was_reset = 1'b0;
      for (int j = 1; j <= TO; j++) begin
        @(negedge clk);
        if (reset_it && j == 2) begin
          rst_n = 1'b0;
          #1;
          model_reset();
          check_all_zero("midreset");
          apply_reqs();
          @(negedge clk);
          rst_n     = 1'b1;
          was_reset = 1'b1;
          force_r1  = 1'b1;
          break;
        end
        bus.mem_ready = (j == ready_edge);
        mem_data      = $urandom;
        bus.mem_rdata = mem_data;
        // Owner fields may wander while granted; the latched copy must stay on the bus.
        if ($urandom_range(0, 1) == 1) begin
          if (owner == 0) begin
            bus.r0_address = $urandom;
            bus.r0_wdata   = $urandom;
          end else begin
            bus.r1_address = $urandom;
            bus.r1_wdata   = $urandom;
          end
        end
        @(posedge clk);
        #1;
        if (j == ready_edge || j == TO) begin
          done  = 1'b1;
          timed = (j != ready_edge);
          if (!timed && rnw_m[owner]) rdata_exp[owner] = mem_data;
        end
        check("r0_ready", 64'(bus.r0_ready), 64'(done && owner == 0));
        check("r1_ready", 64'(bus.r1_ready), 64'(done && owner == 1));
        check("err", 64'(err), 64'(done && timed));
        check("mem_en", 64'(bus.mem_enable), 64'(!done));
        check("mem_addr_hold", 64'(bus.mem_address), 64'(addr_m[owner]));
        check("mem_wdata_hold", 64'(bus.mem_wdata), 64'(wdata_m[owner]));
        check("grant_hold", 64'(grant), 64'(grant_exp));
        check_rdata("access");
        if (done) break;
      end
      if (was_reset) continue;

      // DONE cycle: owner releases, stray MEM_READY must be ignored.
      @(negedge clk);
      pend[owner] = 1'b0;
      apply_reqs();
      bus.mem_ready = logic'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("post_ready", 64'({bus.r0_ready, bus.r1_ready}), 64'(0));
      check("post_err", 64'(err), 64'(0));
      check("post_grant", 64'(grant), 64'(0));
      check("post_mem_en", 64'(bus.mem_enable), 64'(0));
      check_rdata("post");
      last_owner = owner;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
